div_issue_ctrl: RTL and testbench

//  Sequences the signed and unsigned divider IP cores on behalf of the EXE stage.

---
 rtl/div_ctrl_pkg.sv | 18 +
 rtl/div_issue_ctrl.sv | 154 +++++++++++++++
 tb/tb_div_issue_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider issue controller.
package div_ctrl_pkg;

    typedef enum logic [2:0] {
        S_RSTQ  = 3'd0,
        S_IDLE  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4,
        S_DRAIN = 3'd5
    } div_state_t;

    localparam int DIV_OP_SIGNED = 1;
    localparam int DIV_OP_MOD    = 0;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_issue_ctrl.sv
// Issues one divide op at a time to the signed/unsigned divider cores and holds the result.
// Optional DIV_ZERO_BYPASS_EN: zero divisors complete locally without touching a core.
module div_issue_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DIV_LATENCY = 40,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        busy,
    output logic        div_tvalid_s,
    input  logic [1:0]  div_tready_s,
    input  logic        div_dvalid_s,
    input  logic [63:0] div_dout_s,
    output logic        div_tvalid_u,
    input  logic [1:0]  div_tready_u,
    input  logic        div_dvalid_u,
    input  logic [63:0] div_dout_u,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor
);

    div_state_t state, state_nxt;

    logic [CNT_W-1:0] quiet_cnt;
    logic [1:0]       op_q;
    logic [31:0]      src1_q;
    logic [31:0]      src2_q;
    logic [31:0]      result_q;

    logic        sel_signed;
    logic [1:0]  tready_sel;
    logic        dvalid_sel;
    logic [63:0] dout_sel;
    logic [31:0] core_result;
    logic        accept;
    logic        handshake;
    logic        zero_bypass;
    logic [31:0] bypass_result;

    assign sel_signed  = op_q[DIV_OP_SIGNED];
    assign tready_sel  = sel_signed ? div_tready_s : div_tready_u;
    assign dvalid_sel  = sel_signed ? div_dvalid_s : div_dvalid_u;
    assign dout_sel    = sel_signed ? div_dout_s   : div_dout_u;
    assign core_result = op_q[DIV_OP_MOD] ? dout_sel[31:0] : dout_sel[63:32];

    assign accept    = req_valid && req_ready;
    assign handshake = (state == S_ISSUE) && !flush && (&tready_sel);

`ifdef DIV_ZERO_BYPASS_EN
    assign zero_bypass = (req_src2 == 32'd0);
`else
    assign zero_bypass = 1'b0;
`endif
    assign bypass_result = req_op[DIV_OP_MOD] ? req_src1 : DIV0_QUOT;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RSTQ;
        end else begin
            state <= state_nxt;
        end
    end

    // The cores have no reset, so the quiet counter lets any pre-reset result fall out unseen.
    always_ff @(posedge clk) begin
        if (reset) begin
            quiet_cnt <= CNT_W'(DIV_LATENCY);
            op_q      <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            result_q  <= '0;
        end else begin
            if (state == S_RSTQ && quiet_cnt != '0) begin
                quiet_cnt <= quiet_cnt - 1'b1;
            end
            if (accept) begin
                op_q   <= req_op;
                src1_q <= req_src1;
                src2_q <= req_src2;
            end
            if (accept && zero_bypass) begin
                result_q <= bypass_result;
            end else if (state == S_WAIT && dvalid_sel && !flush) begin
                result_q <= core_result;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RSTQ: begin
                if (quiet_cnt == '0) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (accept) state_nxt = zero_bypass ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                if (flush)          state_nxt = S_IDLE;
                else if (handshake) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A result landing together with the flush is already drained.
                if (flush)           state_nxt = dvalid_sel ? S_IDLE : S_DRAIN;
                else if (dvalid_sel) state_nxt = S_DONE;
            end
            S_DRAIN: begin
                if (dvalid_sel) state_nxt = S_IDLE;
            end
            S_DONE: begin
                if (flush || resp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_RSTQ;
        endcase
    end

    always_comb begin
        req_ready    = 1'b0;
        busy         = 1'b1;
        resp_valid   = 1'b0;
        div_tvalid_s = 1'b0;
        div_tvalid_u = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = !flush;
                busy      = 1'b0;
            end
            S_ISSUE: begin
                if (sel_signed) div_tvalid_s = !flush;
                else            div_tvalid_u = !flush;
            end
            S_DONE: begin
                resp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign resp_data    = result_q;
    assign div_dividend = src1_q;
    assign div_divisor  = src2_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl; the bench plays both divider cores with directed responses.
// Build with DIV_ZERO_BYPASS_EN to exercise the zero-divisor bypass.
module tb_div_issue_ctrl;

    localparam int DIV_LATENCY = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        busy;
    logic        div_tvalid_s;
    logic [1:0]  div_tready_s;
    logic        div_dvalid_s;
    logic [63:0] div_dout_s;
    logic        div_tvalid_u;
    logic [1:0]  div_tready_u;
    logic        div_dvalid_u;
    logic [63:0] div_dout_u;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expq[$];

    always #5 clk = ~clk;

    div_issue_ctrl #(
        .DIV_LATENCY(DIV_LATENCY),
        .CNT_W      (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_src1    (req_src1),
        .req_src2    (req_src2),
        .flush       (flush),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .busy        (busy),
        .div_tvalid_s(div_tvalid_s),
        .div_tready_s(div_tready_s),
        .div_dvalid_s(div_dvalid_s),
        .div_dout_s  (div_dout_s),
        .div_tvalid_u(div_tvalid_u),
        .div_tready_u(div_tready_u),
        .div_dvalid_u(div_dvalid_u),
        .div_dout_u  (div_dout_u),
        .div_dividend(div_dividend),
        .div_divisor (div_divisor)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Monitor: every transfer the DUT completes must match the oldest expected result.
    always @(negedge clk) begin
        if (!reset && resp_valid && resp_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_resp: got %h, expected no response", resp_data);
            end else begin
                checkOutput("resp_data", resp_data, expq.pop_front());
            end
        end
    end

    // Called and returns at posedge+1; pushes the expected result once the request is accepted.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp, input bit push);
        int n = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkBit("req_accept", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (push) expq.push_back(exp);
    endtask

    task automatic runCore(input bit sgn, input int stall, input int lat, input logic [63:0] dout);
        for (int i = 0; i < stall; i++) begin
            if (sgn) div_tready_s = 2'b01;
            else     div_tready_u = 2'b10;
            @(negedge clk);
            checkBit("tvalid_held", sgn ? div_tvalid_s : div_tvalid_u, 1'b1);
            checkBit("tvalid_other", sgn ? div_tvalid_u : div_tvalid_s, 1'b0);
            @(posedge clk);
            #1;
        end
        if (sgn) div_tready_s = 2'b11;
        else     div_tready_u = 2'b11;
        @(posedge clk);
        #1;
        div_tready_s = 2'b00;
        div_tready_u = 2'b00;
        repeat (lat) @(posedge clk);
        #1;
        if (sgn) begin
            div_dvalid_s = 1'b1;
            div_dout_s   = dout;
        end else begin
            div_dvalid_u = 1'b1;
            div_dout_u   = dout;
        end
        @(posedge clk);
        #1;
        div_dvalid_s = 1'b0;
        div_dvalid_u = 1'b0;
        div_dout_s   = 64'hA5A5_A5A5_5A5A_5A5A;
        div_dout_u   = 64'hA5A5_A5A5_5A5A_5A5A;
    endtask

    // Returns at the negedge where resp_valid is seen.
    task automatic waitResp(input int bound);
        int n = 0;
        @(negedge clk);
        while (!resp_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkBit("resp_arrives", resp_valid, 1'b1);
    endtask

    task automatic waitReady(input int bound);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkBit("req_ready_rises", req_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic bad;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_op       = 2'b00;
        req_src1     = '0;
        req_src2     = '0;
        flush        = 1'b0;
        resp_ready   = 1'b1;
        div_tready_s = 2'b00;
        div_tready_u = 2'b00;
        div_dvalid_s = 1'b0;
        div_dvalid_u = 1'b0;
        div_dout_s   = '0;
        div_dout_u   = '0;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkBit("rst_req_ready", req_ready, 1'b0);
        checkBit("rst_resp_valid", resp_valid, 1'b0);
        checkBit("rst_busy", busy, 1'b1);
        checkBit("rst_tvalid_s", div_tvalid_s, 1'b0);
        checkBit("rst_tvalid_u", div_tvalid_u, 1'b0);
        checkOutput("rst_resp_data", resp_data, 32'd0);
        checkOutput("rst_dividend", div_dividend, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        waitReady(DIV_LATENCY + 10);

        $display("[TB] signed 100 / -7");
        applyStimulus(2'b10, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b1);
        @(negedge clk);
        checkOutput("dividend", div_dividend, 32'd100);
        checkOutput("divisor", div_divisor, 32'hFFFF_FFF9);
        @(posedge clk);
        #1;
        runCore(1'b1, 2, 6, {32'hFFFF_FFF2, 32'd2});
        waitResp(20);
        @(posedge clk);
        #1;

        $display("[TB] unsigned 0xFFFFFFFF %% 10 with resp_ready stalled");
        resp_ready = 1'b0;
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'd10, 32'd5, 1'b1);
        runCore(1'b0, 0, 8, {32'h1999_9999, 32'd5});
        waitResp(20);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkBit("stall_resp_valid", resp_valid, 1'b1);
            checkOutput("stall_resp_data", resp_data, 32'd5);
            checkBit("stall_req_ready", req_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] flush during WAIT, drain stale result");
        applyStimulus(2'b10, 32'd50, 32'd5, 32'd0, 1'b0);
        div_tready_s = 2'b11;
        @(posedge clk);
        #1;
        div_tready_s = 2'b00;
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bad   = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            bad = bad | resp_valid | req_ready | !busy;
            @(posedge clk);
            #1;
        end
        checkBit("drain_quiet", bad, 1'b0);
        div_dvalid_s = 1'b1;
        div_dout_s   = {32'd10, 32'd0};
        @(posedge clk);
        #1;
        div_dvalid_s = 1'b0;
        @(negedge clk);
        checkBit("drain_no_resp", resp_valid, 1'b0);
        checkBit("drain_back_idle", req_ready, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(2'b10, 32'd7, 32'd2, 32'd3, 1'b1);
        runCore(1'b1, 0, 5, {32'd3, 32'd1});
        waitResp(20);
        @(posedge clk);
        #1;

        $display("[TB] reset mid-WAIT with a late core result");
        applyStimulus(2'b00, 32'd20, 32'd4, 32'd0, 1'b0);
        div_tready_u = 2'b11;
        @(posedge clk);
        #1;
        div_tready_u = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkBit("midrst_busy", busy, 1'b1);
        checkBit("midrst_resp_valid", resp_valid, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bad   = 1'b0;
        for (int i = 0; i < DIV_LATENCY; i++) begin
            div_dvalid_u = (i == 5);
            div_dout_u   = {32'd5, 32'd0};
            @(negedge clk);
            bad = bad | req_ready | resp_valid | !busy;
            @(posedge clk);
            #1;
        end
        div_dvalid_u = 1'b0;
        checkBit("rstq_quiet", bad, 1'b0);
        waitReady(5);

        $display("[TB] flush against request and against issue handshake");
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_src1  = 32'd11;
        req_src2  = 32'd3;
        flush     = 1'b1;
        @(negedge clk);
        checkBit("flush_idle_ready", req_ready, 1'b0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        checkBit("flush_idle_not_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(2'b00, 32'd8, 32'd2, 32'd0, 1'b0);
        div_tready_u = 2'b11;
        flush        = 1'b1;
        @(negedge clk);
        checkBit("flush_issue_tvalid", div_tvalid_u, 1'b0);
        @(posedge clk);
        #1;
        flush        = 1'b0;
        div_tready_u = 2'b00;
        @(negedge clk);
        checkBit("flush_issue_idle", busy, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(2'b00, 32'd9, 32'd2, 32'd4, 1'b1);
        runCore(1'b0, 1, 3, {32'd4, 32'd1});
        waitResp(20);
        @(posedge clk);
        #1;

`ifdef DIV_ZERO_BYPASS_EN
        $display("[TB] zero divisor bypass");
        applyStimulus(2'b10, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        checkBit("bypass_resp_valid", resp_valid, 1'b1);
        checkBit("bypass_tvalid_s", div_tvalid_s, 1'b0);
        checkBit("bypass_tvalid_u", div_tvalid_u, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(2'b11, 32'd9, 32'd0, 32'd9, 1'b1);
        @(negedge clk);
        checkBit("bypass_mod_valid", resp_valid, 1'b1);
        checkBit("bypass_mod_tvalid", div_tvalid_s, 1'b0);
        @(posedge clk);
        #1;
`else
        $display("[TB] zero divisor issued to the core");
        applyStimulus(2'b10, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b1);
        runCore(1'b1, 1, 4, {32'hFFFF_FFFF, 32'd9});
        waitResp(20);
        @(posedge clk);
        #1;
`endif

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
